// File: rtl/uart_tx_arbiter.sv
// Round-robin packet arbiter in front of a single uart_tx byte transmitter.
// A granted requester keeps the transmitter until its last byte is accepted.

module uart_tx_arbiter_lane #(
  parameter int IDX = 0
) (
  input  logic       start,
  input  logic       valid,
  input  logic       locked,
  input  logic [2:0] grant_id,
  output logic       elig,
  output logic       ready
);
  logic hit;
  assign hit   = (grant_id == 3'(IDX));
  assign elig  = valid && (!locked || hit);
  assign ready = start && hit;
endmodule

module uart_tx_arbiter #(
  parameter int NUM_REQ      = 4,
  parameter int BUSY_TIMEOUT = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  logic [8*NUM_REQ-1:0] req_data,
  input  logic [NUM_REQ-1:0]   req_last,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic                 tx_start,
  output logic [7:0]           tx_data,
  input  logic                 tx_busy,
  output logic [2:0]           grant_id,
  output logic                 locked,
  output logic                 busy_err
);
  localparam int TW = $clog2(BUSY_TIMEOUT + 1);

  typedef enum logic [1:0] {IDLE, START, WAIT_BUSY, WAIT_DONE} state_t;

  state_t             state, state_d;
  logic [2:0]         rr_ptr, cand, cand_inc;
  logic               found, accept, timeout;
  logic [TW-1:0]      timer;
  logic [NUM_REQ-1:0] elig;

  assign tx_start = (state == START);

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_lane
    uart_tx_arbiter_lane #(.IDX(i)) u_lane (
      .start    (tx_start),
      .valid    (req_valid[i]),
      .locked   (locked),
      .grant_id (grant_id),
      .elig     (elig[i]),
      .ready    (req_ready[i])
    );
  end

  // While locked only grant_id is eligible, so the same search yields it.
  always_comb begin
    int j;
    j     = 0;
    found = 1'b0;
    cand  = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      j = int'(rr_ptr) + k;
      if (j >= NUM_REQ) j = j - NUM_REQ;
      if (!found && elig[j]) begin
        found = 1'b1;
        cand  = 3'(j);
      end
    end
  end

  assign cand_inc = (int'(cand) == NUM_REQ - 1) ? 3'd0 : cand + 3'd1;
  assign accept   = (state == IDLE) && !tx_busy && found;
  assign timeout  = (timer == TW'(BUSY_TIMEOUT - 1));

  always_comb begin
    state_d = state;
    case (state)
      IDLE:      if (accept) state_d = START;
      START:     state_d = WAIT_BUSY;
      WAIT_BUSY: if (tx_busy) state_d = WAIT_DONE;
                 else if (timeout) state_d = IDLE;
      WAIT_DONE: if (!tx_busy) state_d = IDLE;
      default:   state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rr_ptr   <= '0;
      timer    <= '0;
      tx_data  <= '0;
      grant_id <= '0;
      locked   <= 1'b0;
      busy_err <= 1'b0;
    end else begin
      if (accept) begin
        tx_data  <= req_data[8*int'(cand) +: 8];
        grant_id <= cand;
        locked   <= ~req_last[cand];
        if (req_last[cand]) rr_ptr <= cand_inc;
      end
      // A lost byte is counted as sent; the packet continues normally.
      if (state == START) timer <= '0;
      else if (state == WAIT_BUSY && !tx_busy) begin
        if (timeout) busy_err <= 1'b1;
        else         timer    <= timer + 1'b1;
      end
    end
  end
endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter with a small uart_tx busy model and
// per-requester byte queues.

module tb_uart_tx_arbiter;
  localparam int N  = 4;
  localparam int TO = 16;

  logic           clk = 1'b0;
  logic           rst = 1'b1;
  logic [N-1:0]   req_valid = '0;
  logic [8*N-1:0] req_data = '0;
  logic [N-1:0]   req_last = '0;
  logic [N-1:0]   req_ready;
  logic           tx_start;
  logic [7:0]     tx_data;
  logic           tx_busy = 1'b0;
  logic [2:0]     grant_id;
  logic           locked;
  logic           busy_err;

  uart_tx_arbiter #(.NUM_REQ(N), .BUSY_TIMEOUT(TO)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .tx_start(tx_start),
    .tx_data(tx_data), .tx_busy(tx_busy), .grant_id(grant_id),
    .locked(locked), .busy_err(busy_err)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic [2:0] g; logic [7:0] d; logic lk;} ent_t;

  logic [8:0]   srcq [N][$];
  ent_t         log_q[$];
  logic [8:0]   f;
  logic [N-1:0] exp_rdy;
  int total = 0, bad = 0, ready_bad = 0;
  bit model_en = 1'b1;
  int busy_cnt = 0;
  int busy_len = 4;

  // Monitor, uart_tx model and requester drivers, all on the falling edge.
  always @(negedge clk) begin
    exp_rdy = '0;
    if (tx_start) begin
      log_q.push_back({grant_id, tx_data, locked});
      exp_rdy[grant_id] = 1'b1;
    end
    if (req_ready !== exp_rdy) ready_bad++;
    if (model_en) begin
      if (tx_start) begin
        tx_busy  = 1'b1;
        busy_cnt = busy_len;
      end else if (busy_cnt > 0) begin
        busy_cnt--;
        if (busy_cnt == 0) tx_busy = 1'b0;
      end
    end
    for (int i = 0; i < N; i++) begin
      if (req_ready[i] && srcq[i].size() > 0) void'(srcq[i].pop_front());
      if (srcq[i].size() > 0) begin
        f = srcq[i][0];
        req_valid[i] = 1'b1;
        req_data[8*i +: 8] = f[7:0];
        req_last[i] = f[8];
      end else begin
        req_valid[i] = 1'b0;
        req_last[i] = 1'b0;
      end
    end
  end

  task automatic do_reset();
    for (int i = 0; i < N; i++) srcq[i].delete();
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    log_q.delete();
  endtask

  task automatic wait_drain(input string name);
    bit done = 1'b0;
    int pend;
    for (int c = 0; c < 400 && !done; c++) begin
      @(posedge clk); #1;
      pend = 0;
      for (int i = 0; i < N; i++) pend += srcq[i].size();
      if (pend == 0 && !tx_busy && !tx_start && busy_cnt == 0) done = 1'b1;
    end
    repeat (3) @(posedge clk);
    #1;
    total++;
    if (done !== 1'b1) begin bad++; $display("FAIL %s drain timeout", name); end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    @(posedge clk); #1;
    total += 6;
    if (tx_start !== 1'b0)  begin bad++; $display("FAIL rst_tx_start got=%b exp=0", tx_start); end
    if (req_ready !== '0)   begin bad++; $display("FAIL rst_ready got=%b exp=0", req_ready); end
    if (tx_data !== 8'h00)  begin bad++; $display("FAIL rst_tx_data got=%h exp=00", tx_data); end
    if (grant_id !== 3'd0)  begin bad++; $display("FAIL rst_grant got=%0d exp=0", grant_id); end
    if (locked !== 1'b0)    begin bad++; $display("FAIL rst_locked got=%b exp=0", locked); end
    if (busy_err !== 1'b0)  begin bad++; $display("FAIL rst_busy_err got=%b exp=0", busy_err); end
    rst = 1'b0;
  endtask

  task automatic test_single();
    do_reset();
    srcq[0].push_back({1'b1, 8'h4D});
    @(posedge clk); #1;
    total += 5;
    if (tx_start !== 1'b1)     begin bad++; $display("FAIL single_start got=%b exp=1", tx_start); end
    if (req_ready !== 4'b0001) begin bad++; $display("FAIL single_ready got=%b exp=0001", req_ready); end
    if (tx_data !== 8'h4D)     begin bad++; $display("FAIL single_data got=%h exp=4d", tx_data); end
    if (grant_id !== 3'd0)     begin bad++; $display("FAIL single_grant got=%0d exp=0", grant_id); end
    if (locked !== 1'b0)       begin bad++; $display("FAIL single_locked got=%b exp=0", locked); end
    @(posedge clk); #1;
    total++;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL single_start_len got=%b exp=0", tx_start); end
    wait_drain("single");
    total++;
    if (log_q.size() !== 1) begin bad++; $display("FAIL single_count got=%0d exp=1", log_q.size()); end
  endtask

  task automatic test_round_robin();
    ent_t exp_q[$];
    do_reset();
    srcq[0].push_back({1'b1, 8'h41});
    srcq[0].push_back({1'b1, 8'h41});
    srcq[2].push_back({1'b1, 8'h43});
    wait_drain("rr_a");
    srcq[0].push_back({1'b1, 8'h30});
    srcq[1].push_back({1'b1, 8'h31});
    wait_drain("rr_b");
    exp_q.push_back({3'd0, 8'h41, 1'b0});
    exp_q.push_back({3'd2, 8'h43, 1'b0});
    exp_q.push_back({3'd0, 8'h41, 1'b0});
    exp_q.push_back({3'd1, 8'h31, 1'b0});
    exp_q.push_back({3'd0, 8'h30, 1'b0});
    total++;
    if (log_q.size() !== exp_q.size())
      begin bad++; $display("FAIL rr_count got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL rr_entry%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_packet_lock();
    ent_t exp_q[$];
    do_reset();
    srcq[1].push_back({1'b0, 8'h4F});
    srcq[1].push_back({1'b0, 8'h4B});
    srcq[1].push_back({1'b1, 8'h0A});
    srcq[3].push_back({1'b1, 8'h58});
    wait_drain("lock");
    exp_q.push_back({3'd1, 8'h4F, 1'b1});
    exp_q.push_back({3'd1, 8'h4B, 1'b1});
    exp_q.push_back({3'd1, 8'h0A, 1'b0});
    exp_q.push_back({3'd3, 8'h58, 1'b0});
    total++;
    if (log_q.size() !== exp_q.size())
      begin bad++; $display("FAIL lock_count got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL lock_entry%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_busy_timeout();
    bit seen = 1'b0;
    do_reset();
    model_en = 1'b0;
    tx_busy  = 1'b0;
    srcq[0].push_back({1'b1, 8'h11});
    srcq[1].push_back({1'b1, 8'h22});
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (tx_start) seen = 1'b1;
    end
    total++;
    if (seen !== 1'b1) begin bad++; $display("FAIL to_first_start got=0 exp=1"); end
    repeat (16) @(posedge clk);
    #1;
    total++;
    if (busy_err !== 1'b0) begin bad++; $display("FAIL to_early got=%b exp=0", busy_err); end
    @(posedge clk); #1;
    total += 2;
    if (busy_err !== 1'b1) begin bad++; $display("FAIL to_flag got=%b exp=1", busy_err); end
    if (tx_start !== 1'b0) begin bad++; $display("FAIL to_idle got=%b exp=0", tx_start); end
    @(posedge clk); #1;
    total += 3;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL to_next_start got=%b exp=1", tx_start); end
    if (grant_id !== 3'd1) begin bad++; $display("FAIL to_next_grant got=%0d exp=1", grant_id); end
    if (tx_data !== 8'h22) begin bad++; $display("FAIL to_next_data got=%h exp=22", tx_data); end
    repeat (24) @(posedge clk);
    #1;
    total++;
    if (busy_err !== 1'b1) begin bad++; $display("FAIL to_sticky got=%b exp=1", busy_err); end
    model_en = 1'b1;
  endtask

  task automatic test_busy_hold();
    bit seen = 1'b0;
    model_en = 1'b0;
    tx_busy  = 1'b1;
    do_reset();
    srcq[2].push_back({1'b1, 8'h55});
    repeat (6) begin
      @(posedge clk); #1;
      if (tx_start) seen = 1'b1;
    end
    total += 2;
    if (seen !== 1'b0)     begin bad++; $display("FAIL hold_no_start got=1 exp=0"); end
    if (busy_err !== 1'b0) begin bad++; $display("FAIL hold_err_clear got=%b exp=0", busy_err); end
    tx_busy  = 1'b0;
    model_en = 1'b1;
    @(posedge clk); #1;
    total += 3;
    if (tx_start !== 1'b1) begin bad++; $display("FAIL hold_start got=%b exp=1", tx_start); end
    if (tx_data !== 8'h55) begin bad++; $display("FAIL hold_data got=%h exp=55", tx_data); end
    if (grant_id !== 3'd2) begin bad++; $display("FAIL hold_grant got=%0d exp=2", grant_id); end
    wait_drain("hold");
  endtask

  task automatic test_reset_mid_packet();
    bit seen = 1'b0;
    ent_t exp_q[$];
    busy_len = 4;
    do_reset();
    srcq[1].push_back({1'b0, 8'h41});
    srcq[1].push_back({1'b1, 8'h42});
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge clk); #1;
      if (tx_start) seen = 1'b1;
    end
    total += 2;
    if (seen !== 1'b1)   begin bad++; $display("FAIL mid_first_start got=0 exp=1"); end
    if (locked !== 1'b1) begin bad++; $display("FAIL mid_locked got=%b exp=1", locked); end
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
    srcq[0].push_back({1'b1, 8'h77});
    @(posedge clk); #1;
    total += 6;
    if (tx_start !== 1'b0) begin bad++; $display("FAIL mid_rst_start got=%b exp=0", tx_start); end
    if (req_ready !== '0)  begin bad++; $display("FAIL mid_rst_ready got=%b exp=0", req_ready); end
    if (tx_data !== 8'h00) begin bad++; $display("FAIL mid_rst_data got=%h exp=00", tx_data); end
    if (grant_id !== 3'd0) begin bad++; $display("FAIL mid_rst_grant got=%0d exp=0", grant_id); end
    if (locked !== 1'b0)   begin bad++; $display("FAIL mid_rst_locked got=%b exp=0", locked); end
    if (busy_err !== 1'b0) begin bad++; $display("FAIL mid_rst_err got=%b exp=0", busy_err); end
    rst = 1'b0;
    log_q.delete();
    wait_drain("mid");
    exp_q.push_back({3'd0, 8'h77, 1'b0});
    exp_q.push_back({3'd1, 8'h42, 1'b0});
    total++;
    if (log_q.size() !== exp_q.size())
      begin bad++; $display("FAIL mid_count got=%0d exp=%0d", log_q.size(), exp_q.size()); end
    for (int i = 0; i < exp_q.size(); i++) begin
      total++;
      if (i >= log_q.size() || log_q[i] !== exp_q[i]) begin
        bad++;
        $display("FAIL mid_entry%0d got=%h exp=%h", i, (i < log_q.size()) ? log_q[i] : '0, exp_q[i]);
      end
    end
  endtask

  task automatic test_ready_rules();
    total++;
    if (ready_bad !== 0) begin bad++; $display("FAIL ready_onehot got=%0d exp=0", ready_bad); end
  endtask

  initial begin
    test_reset();
    test_single();
    test_round_robin();
    test_packet_lock();
    test_busy_timeout();
    test_busy_hold();
    test_reset_mid_packet();
    test_ready_rules();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
